// File: rtl/BasicTypes.sv
// BasicTypes: shared execute-stage types, including the mul/div op codes and unit states.
package BasicTypes;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } MulDivCode;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } MulDivState;

    function automatic logic is_div(input MulDivCode op);
        return op[2];
    endfunction

    function automatic logic is_rem(input MulDivCode op);
        return op[2] & op[1];
    endfunction

    function automatic logic rs1_signed(input MulDivCode op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic rs2_signed(input MulDivCode op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: magnitude shift-add multiplier / restoring divider with sign fixup and fast-path results.
module muldiv_datapath
    import BasicTypes::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            start,
    input  logic            step,
    input  logic            fixup,
    input  MulDivCode       op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            fast,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] acc_q, acc_d, step_val, mul_prod;
    logic [XLEN-1:0]   opnd_q, opnd_d, result_q, result_d;
    logic [XLEN-1:0]   mag1, mag2, fast_val, div_v, fix_val;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    MulDivCode         op_q, op_d;
    logic              neg_q, neg_d;
    logic              a_neg, b_neg, div_zero, ovf, ge;

    always_comb begin
        a_neg    = rs1_signed(op) && src1[XLEN-1];
        b_neg    = rs2_signed(op) && src2[XLEN-1];
        mag1     = a_neg ? -src1 : src1;
        mag2     = b_neg ? -src2 : src2;
        div_zero = is_div(op) && src2 == '0;
        ovf      = (op == MD_DIV || op == MD_REM) && src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1;
        fast     = div_zero || ovf;
        fast_val = div_zero ? (is_rem(op) ? src1 : '1) : (is_rem(op) ? '0 : src1);
        // mul: add multiplicand into the high half, shift right; div: shift left, trial-subtract
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_sh - {1'b0, opnd_q};
        ge       = ~div_diff[XLEN];
        step_val = is_div(op_q) ? {ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0], acc_q[XLEN-2:0], ge}
                                : {mul_sum, acc_q[XLEN-1:1]};
        mul_prod = neg_q ? -acc_q : acc_q;
        div_v    = is_rem(op_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        fix_val  = is_div(op_q) ? (neg_q ? -div_v : div_v)
                                : (op_q == MD_MUL ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN]);
        acc_d    = start ? {{XLEN{1'b0}}, mag1} : step ? step_val : acc_q;
        opnd_d   = start ? mag2 : opnd_q;
        op_d     = start ? op : op_q;
        neg_d    = start ? (is_rem(op) ? a_neg : a_neg ^ b_neg) : neg_q;
        result_d = (start && fast) ? fast_val : fixup ? fix_val : result_q;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready request and response channels.
module muldiv_unit
    import BasicTypes::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 flush,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  MulDivCode            reqOp,
    input  logic [XLEN-1:0]      reqSrc1,
    input  logic [XLEN-1:0]      reqSrc2,
    input  logic [TAG_WIDTH-1:0] reqTag,
    output logic                 respValid,
    input  logic                 respReady,
    output logic [XLEN-1:0]      respData,
    output logic [TAG_WIDTH-1:0] respTag
);

    localparam int CW = $clog2(XLEN) + 1;

    MulDivState           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic                 accept, fast, step, fixup;

    assign reqReady = state_q == IDLE && !flush;
    assign accept   = reqValid && reqReady;
    assign step     = state_q == BUSY && !flush;
    assign fixup    = state_q == FIXUP && !flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast ? DONE : BUSY;
            BUSY:    if (cnt_q == CW'(1)) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    if (respReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
        cnt_d = flush ? '0 : accept ? CW'(XLEN) : step ? cnt_q - CW'(1) : cnt_q;
        tag_d = accept ? reqTag : tag_q;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_dp (
        .clk    (clk),
        .rstN   (rstN),
        .start  (accept),
        .step   (step),
        .fixup  (fixup),
        .op     (reqOp),
        .src1   (reqSrc1),
        .src2   (reqSrc2),
        .fast   (fast),
        .result (respData)
    );

    assign respValid = state_q == DONE;
    assign respTag   = tag_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit, the multi-cycle companion to the single-cycle ALU in the execute stage. It accepts one operation at a time over a valid/ready request channel. It computes the result with a radix-2 shift-add multiplier or a restoring divider over `XLEN` iterations, and returns the result plus a destination tag over a valid/ready response channel. A pipeline flush aborts any in-flight operation.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; must be ≥ 2.
- `TAG_WIDTH`, 5: width of the opaque tag carried from request to response (default fits a `RegAddr`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstN`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  abort the in-flight operation and discard its result.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  unit can accept a request this cycle.
- `reqOp`  in  `MulDivCode`  operation select.
- `reqSrc1`, `reqSrc2`  in  `XLEN`  rs1, rs2 operands.
- `reqTag`  in  `TAG_WIDTH`  tag returned with the result.
- `respValid`  out  1  result present.
- `respReady`  in  1  consumer takes the result.
- `respData`  out  `XLEN`  result.
- `respTag`  out  `TAG_WIDTH`  tag of the result.

## Operation
- States: IDLE, BUSY, FIXUP, DONE.
- `reqReady = (state == IDLE) && !flush`. A request is accepted when `reqValid && reqReady`. On acceptance, the unit latches op, tag and operands.
- Sign handling:
  - MUL, MULH, DIV, REM treat both operands as signed.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MULHU, DIVU, REMU treat both as unsigned.
  - Signed operands are converted to magnitudes at accept. The result negation flag is recorded.
- Multiply: 2·`XLEN` accumulator, one partial product per BUSY cycle. MUL returns the low `XLEN` bits of the signed-corrected product. The MULH* ops return the high `XLEN` bits.
- Divide: restoring, one quotient bit per BUSY cycle.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Fast paths: accept goes directly to DONE with no iteration.
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return rs1.
  - Signed overflow (rs1 = most-negative, rs2 = −1): DIV returns rs1; REM returns 0.
- Transitions:
  - IDLE → BUSY on accept (or → DONE on a fast path).
  - BUSY → FIXUP after exactly `XLEN` BUSY cycles. An iteration counter of `$clog2(XLEN)+1` bits counts down to 0.
  - FIXUP → DONE; FIXUP applies the sign correction and registers `respData`.
  - DONE → IDLE when `respReady`.
- `respValid = (state == DONE)`. `respData`/`respTag` hold stable while `respValid && !respReady`.
- Flush has priority over every other event:
  - Any state → IDLE on the next edge; `respValid` is low from that edge.
  - A same-cycle `reqValid` is not accepted.
  - A same-cycle `respReady` in DONE is still a completed handshake; the consumer may use that result.

## Timing
- Reset (async, `rstN` low): state = IDLE, `respValid` = 0, `respData` = 0, `respTag` = 0, counter = 0. `reqReady` = 1 once `rstN` is high and `flush` is low.
- Iterative latency: accept at edge T. BUSY covers cycles T+1 … T+`XLEN`, FIXUP is cycle T+`XLEN`+1, and `respValid` goes high in cycle T+`XLEN`+2 (34 cycles for `XLEN`=32).
- Fast-path latency: `respValid` goes high in cycle T+1.
- Throughput: with `respReady` held high, the next request can be accepted in the cycle after the DONE handshake. There is no accept in the same cycle as DONE.
- Reset mid-operation: immediate return to IDLE with all outputs cleared. There is no partial result.

## Structure
- Add to the shared `BasicTypes` package: `typedef enum logic [2:0] MulDivCode` with MD_MUL=0, MD_MULH=1, MD_MULHSU=2, MD_MULHU=3, MD_DIV=4, MD_DIVU=5, MD_REM=6, MD_REMU=7.
- Also add to `BasicTypes`: the state enum `MulDivState`.
- Sub-module `muldiv_datapath` holds the accumulator/remainder registers and the iteration step. It is driven by the FSM in `muldiv_unit` through start/step/fixup strobes.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD), tag 5 → `respData` 0xFFFFFFEB, `respTag` 5, `respValid` exactly 34 cycles after accept.
- MULH/MULHSU/MULHU with 0x80000000 × 0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV −7 ÷ 2 → 0xFFFFFFFD; REM −7 ÷ 2 → 0xFFFFFFFF; DIVU 100 ÷ 7 → 14; REMU 100 ÷ 7 → 2.
- DIV/REM x ÷ 0 (x=0x1234) → 0xFFFFFFFF / 0x1234. DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000, REM → 0. All of these have `respValid` 1 cycle after accept.
- Backpressure: `respReady` low for 10 cycles in DONE → `respValid`/`respData`/`respTag` stable. `reqReady` stays 0 until the handshake.
- Flush in BUSY cycle 10 with a concurrent `reqValid` → no accept. `respValid` stays 0 and `reqReady` is 1 next cycle. A following MULHU 3 × 5 → 0.
